// File: rtl/oddr2_pkg.sv
// oddr2_pkg: encodings and parameter checks shared by the ODDR2-style DDR output model.
// Alignment selects which clock edge samples the data inputs. SR type selects whether
// r/s are sampled at the register's edge or act immediately.
package oddr2_pkg;

  // Data alignment modes
  localparam int ALIGN_NONE = 0;
  localparam int ALIGN_C0   = 1;
  localparam int ALIGN_C1   = 2;

  // Set/reset behaviour
  localparam int SR_SYNC    = 0;
  localparam int SR_ASYNC   = 1;

  // Edge select for a single register: C0 = rising clk, C1 = falling clk
  localparam int EDGE_C0    = 0;
  localparam int EDGE_C1    = 1;

  // True when both parameter encodings are legal
  function automatic bit oddr2_params_ok(input int align, input int srtype);
    return ((align == ALIGN_NONE) || (align == ALIGN_C0) || (align == ALIGN_C1)) &&
           ((srtype == SR_SYNC) || (srtype == SR_ASYNC));
  endfunction

endpackage

// File: rtl/oddr2_model_ddr_edge_reg.sv
// ddr_edge_reg: one-bit register clocked on the rising (EDGE_C0) or falling (EDGE_C1)
// edge of i_clk.
// Priority at the edge: r -> 0, then s -> 1, then ce -> d, otherwise hold.
// With SR_ASYNC, r and s also act immediately, without waiting for an edge.
// i_rst_n is active low and asynchronous. It loads INIT and overrides everything else.
module ddr_edge_reg
  import oddr2_pkg::*;
#(
  parameter int   EDGE   = EDGE_C0,
  parameter logic INIT   = 1'b1,
  parameter int   SRTYPE = SR_SYNC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ce,
  input  logic i_d,
  input  logic i_r,
  input  logic i_s,
  output logic o_q
);

  logic w_clk;
  logic r_q;

  // A falling-edge register is a rising-edge register on the inverted clock
  assign w_clk = (EDGE == EDGE_C1) ? ~i_clk : i_clk;

  generate
    if (SRTYPE == SR_ASYNC) begin : g_async
      // r/s take effect on their own rising edge; the clock edge applies the same priority
      always_ff @(posedge w_clk or negedge i_rst_n or posedge i_r or posedge i_s) begin
        if (!i_rst_n)  r_q <= INIT;
        else if (i_r)  r_q <= 1'b0;
        else if (i_s)  r_q <= 1'b1;
        else if (i_ce) r_q <= i_d;
      end
    end else begin : g_sync
      // r/s are sampled only at the register's own clock edge
      always_ff @(posedge w_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_q <= INIT;
        else if (i_r)  r_q <= 1'b0;
        else if (i_s)  r_q <= 1'b1;
        else if (i_ce) r_q <= i_d;
      end
    end
  endgenerate

  assign o_q = r_q;

endmodule

// File: rtl/oddr2_model.sv
// oddr2_model: single-clock DDR output register in the style of ODDR2.
// q0 is loaded on the rising edge and drives q_out while clk_in is high.
// q1 is loaded on the falling edge and drives q_out while clk_in is low.
// DDR_ALIGNMENT can sample both data bits on one edge and carry the second bit through a
// stage register.
// Build option ODDR2_CE_EN: when defined, ce_in gates data capture. When undefined,
// ce_in is ignored and capture is always enabled.
module oddr2_model
  import oddr2_pkg::*;
#(
  parameter logic INIT          = 1'b1,
  parameter int   DDR_ALIGNMENT = ALIGN_NONE,
  parameter int   SRTYPE        = SR_SYNC
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic ce_in,
  input  logic d0_in,
  input  logic d1_in,
  input  logic r_in,
  input  logic s_in,
  output logic q_out
);

  logic w_ce;
  logic w_q0_d;
  logic w_q1_d;
  logic w_q0;
  logic w_q1;

  // Reject illegal parameter encodings at elaboration time
  generate
    if (!oddr2_params_ok(DDR_ALIGNMENT, SRTYPE)) begin : g_bad_params
      $fatal(1, "oddr2_model: illegal DDR_ALIGNMENT or SRTYPE encoding");
    end
  endgenerate

`ifdef ODDR2_CE_EN
  assign w_ce = ce_in;
`else
  // The port is kept so the interface is the same in both builds
  logic w_ce_unused;
  assign w_ce_unused = ce_in;
  assign w_ce        = 1'b1;
`endif

  // Route data to q0/q1, through a stage register when one edge samples both bits
  generate
    if (DDR_ALIGNMENT == ALIGN_C0) begin : g_align_c0
      logic w_stage;
      ddr_edge_reg #(.EDGE(EDGE_C0), .INIT(INIT), .SRTYPE(SRTYPE)) u_stage (
        .i_clk(clk_in), .i_rst_n(reset_in), .i_ce(w_ce), .i_d(d1_in),
        .i_r(r_in), .i_s(s_in), .o_q(w_stage)
      );
      assign w_q0_d = d0_in;
      assign w_q1_d = w_stage;
    end else if (DDR_ALIGNMENT == ALIGN_C1) begin : g_align_c1
      logic w_stage;
      ddr_edge_reg #(.EDGE(EDGE_C1), .INIT(INIT), .SRTYPE(SRTYPE)) u_stage (
        .i_clk(clk_in), .i_rst_n(reset_in), .i_ce(w_ce), .i_d(d0_in),
        .i_r(r_in), .i_s(s_in), .o_q(w_stage)
      );
      assign w_q0_d = w_stage;
      assign w_q1_d = d1_in;
    end else begin : g_align_none
      assign w_q0_d = d0_in;
      assign w_q1_d = d1_in;
    end
  endgenerate

  // Rising-edge output register: drives q_out during the high phase
  ddr_edge_reg #(.EDGE(EDGE_C0), .INIT(INIT), .SRTYPE(SRTYPE)) u_q0 (
    .i_clk(clk_in), .i_rst_n(reset_in), .i_ce(w_ce), .i_d(w_q0_d),
    .i_r(r_in), .i_s(s_in), .o_q(w_q0)
  );

  // Falling-edge output register: drives q_out during the low phase
  ddr_edge_reg #(.EDGE(EDGE_C1), .INIT(INIT), .SRTYPE(SRTYPE)) u_q1 (
    .i_clk(clk_in), .i_rst_n(reset_in), .i_ce(w_ce), .i_d(w_q1_d),
    .i_r(r_in), .i_s(s_in), .o_q(w_q1)
  );

  // The clock level selects which register drives the output
  assign q_out = clk_in ? w_q0 : w_q1;

endmodule

// File: tb/tb_oddr2_model.sv
// tb_oddr2_model: checks three builds of oddr2_model that share one set of inputs:
//   index 0 - ALIGN_NONE with SR_SYNC
//   index 1 - ALIGN_C0 with SR_ASYNC
//   index 2 - ALIGN_C1 with SR_SYNC
// Directed sequences compare against hand-derived constants.
// A randomized phase compares all three builds against a per-edge reference model.
module tb_oddr2_model;
  import oddr2_pkg::*;

  localparam bit INIT_V = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       d0;
  logic       d1;
  logic       r;
  logic       s;
  logic [2:0] q;

  int errors = 0;
  int checks = 0;

  // clock block
  initial forever #5 clk = ~clk;

  oddr2_model #(.INIT(INIT_V), .DDR_ALIGNMENT(ALIGN_NONE), .SRTYPE(SR_SYNC)) u_none (
    .clk_in(clk), .reset_in(rst_n), .ce_in(ce), .d0_in(d0), .d1_in(d1),
    .r_in(r), .s_in(s), .q_out(q[0])
  );
  oddr2_model #(.INIT(INIT_V), .DDR_ALIGNMENT(ALIGN_C0), .SRTYPE(SR_ASYNC)) u_c0 (
    .clk_in(clk), .reset_in(rst_n), .ce_in(ce), .d0_in(d0), .d1_in(d1),
    .r_in(r), .s_in(s), .q_out(q[1])
  );
  oddr2_model #(.INIT(INIT_V), .DDR_ALIGNMENT(ALIGN_C1), .SRTYPE(SR_SYNC)) u_c1 (
    .clk_in(clk), .reset_in(rst_n), .ce_in(ce), .d0_in(d0), .d1_in(d1),
    .r_in(r), .s_in(s), .q_out(q[2])
  );

  // ---------------- reference model ----------------
  bit m_q0[3];
  bit m_q1[3];
  bit m_st[3];

  function automatic bit ce_eff(input bit c);
`ifdef ODDR2_CE_EN
    return c;
`else
    return 1'b1;
`endif
  endfunction

  // What one register holds after its edge, given the inputs present at that edge
  function automatic bit next_val(input bit cur, input bit rr, input bit ss,
                                  input bit cc, input bit dd);
    if (rr)      return 1'b0;
    else if (ss) return 1'b1;
    else if (cc) return dd;
    else         return cur;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      m_q0[0] = next_val(m_q0[0], r, s, ce_eff(ce), d0);
      m_q0[1] = next_val(m_q0[1], r, s, ce_eff(ce), d0);
      m_st[1] = next_val(m_st[1], r, s, ce_eff(ce), d1);
      m_q0[2] = next_val(m_q0[2], r, s, ce_eff(ce), m_st[2]);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      m_q1[0] = next_val(m_q1[0], r, s, ce_eff(ce), d1);
      m_q1[1] = next_val(m_q1[1], r, s, ce_eff(ce), m_st[1]);
      m_q1[2] = next_val(m_q1[2], r, s, ce_eff(ce), d1);
      m_st[2] = next_val(m_st[2], r, s, ce_eff(ce), d0);
    end
  end

  function automatic bit exp_q(input int k);
    return clk ? m_q0[k] : m_q1[k];
  endfunction

  // ---------------- driver tasks ----------------
  // Apply one input set. Reset, and r/s on the SR_ASYNC build, update the model at once.
  task automatic drive(input bit rst_v, input bit ce_v, input bit d0_v, input bit d1_v,
                       input bit r_v, input bit s_v);
    rst_n = rst_v;
    ce    = ce_v;
    d0    = d0_v;
    d1    = d1_v;
    r     = r_v;
    s     = s_v;
    if (!rst_v) begin
      for (int k = 0; k < 3; k++) begin
        m_q0[k] = INIT_V;
        m_q1[k] = INIT_V;
        m_st[k] = INIT_V;
      end
    end else if (r_v) begin
      m_q0[1] = 1'b0; m_q1[1] = 1'b0; m_st[1] = 1'b0;
    end else if (s_v) begin
      m_q0[1] = 1'b1; m_q1[1] = 1'b1; m_st[1] = 1'b1;
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #2;
  endtask

  task automatic to_neg();
    @(negedge clk);
    #2;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ce;
    bit d0;
    bit d1;
    bit r;
    bit s;
    bit exp_hi;
    bit exp_lo;
  } vec_t;

  vec_t vecs[9];
  int   rs;

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{1, 1, 0, 0, 1, 1, 1};  // forwarded clock, idle: set holds 1 in both phases
    vecs[1] = '{1, 1, 0, 0, 1, 1, 1};
    vecs[2] = '{1, 1, 0, 0, 1, 1, 1};
    vecs[3] = '{1, 1, 0, 0, 0, 1, 0};  // set released: toggling resumes
    vecs[4] = '{1, 1, 0, 1, 1, 0, 0};  // r wins over s
    vecs[5] = '{1, 0, 1, 0, 0, 0, 1};
    vecs[6] = '{1, 1, 1, 0, 0, 1, 1};
`ifdef ODDR2_CE_EN
    vecs[7] = '{0, 0, 0, 0, 0, 1, 1};  // ce low: hold
    vecs[8] = '{0, 1, 0, 0, 0, 1, 1};
`else
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0};  // ce ignored: data passes
    vecs[8] = '{0, 1, 0, 0, 0, 1, 0};
`endif

    // Reset held while the clock runs: every build shows INIT
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      to_pos();
      for (int k = 0; k < 3; k++) check($sformatf("rst_hi_cfg%0d", k), q[k], INIT_V);
      to_neg();
      for (int k = 0; k < 3; k++) check($sformatf("rst_lo_cfg%0d", k), q[k], INIT_V);
    end

    // Release reset with D0=1, D1=0: q_out follows clk from the next rising edge
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      to_pos();
      for (int k = 0; k < 3; k++) check($sformatf("track_hi_cfg%0d", k), q[k], 1'b1);
      to_neg();
      for (int k = 0; k < 3; k++) check($sformatf("track_lo_cfg%0d", k), q[k], 1'b0);
    end

    // Table vectors on ALIGN_NONE/SR_SYNC
    for (int i = 0; i < 9; i++) begin
      drive(1, vecs[i].ce, vecs[i].d0, vecs[i].d1, vecs[i].r, vecs[i].s);
      to_pos();
      check($sformatf("vec%0d_hi", i), q[0], vecs[i].exp_hi);
      to_neg();
      check($sformatf("vec%0d_lo", i), q[0], vecs[i].exp_lo);
    end

    // r raised in the middle of a high phase: sync build waits for the edge, async acts now
    drive(1, 1, 1, 0, 0, 0);
    to_pos();
    check("pre_r_sync", q[0], 1'b1);
    check("pre_r_async", q[1], 1'b1);
    drive(1, 1, 1, 0, 1, 0);
    #1;
    check("sync_r_hold", q[0], 1'b1);
    check("async_r_now", q[1], 1'b0);
    to_neg();
    check("sync_r_lo", q[0], 1'b0);
    check("async_r_lo", q[1], 1'b0);
    to_pos();
    check("sync_r_hi", q[0], 1'b0);
    drive(1, 1, 1, 0, 0, 0);

    // ALIGN_C0: d1 sampled at the rising edge reaches the following low phase
    to_neg();
    drive(1, 1, 1, 1, 0, 0);
    to_pos();
    check("c0_hi_n", q[1], 1'b1);
    drive(1, 1, 0, 0, 0, 0);
    to_neg();
    check("c0_lo_n", q[1], 1'b1);
    check("none_lo_n", q[0], 1'b0);
    to_pos();
    check("c0_hi_n1", q[1], 1'b0);
    to_neg();
    check("c0_lo_n1", q[1], 1'b0);

    // Randomized phase against the reference model, starting from reset
    drive(0, 1, 0, 0, 0, 0);
    to_pos();
    to_neg();
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      rs = $urandom_range(0, 7);
      drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rs == 0, rs == 1);
      #1;
      for (int k = 0; k < 3; k++)
        check($sformatf("rand%0d_cfg%0d", i, k), q[k], exp_q(k));
      @(clk);
      #2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oddr2_model.md
Name: oddr2_model

Overview:
- Behavioural, single-clock model of a DDR output register in the style of ODDR2.
- d0_in is driven on q_out while clk_in is high and d1_in while clk_in is low, with clock enable, synchronous/asynchronous set/reset and selectable input alignment.
- Its main use is clock forwarding, e.g. the ADC sclk: D0=1, D1=0, S=chip-select-inactive, so q_out idles high and toggles only during reads.

Parameters:
- INIT, 1'b1: power-up and reset_in value of both output registers, and therefore of q_out.
- DDR_ALIGNMENT, ALIGN_NONE: ALIGN_NONE, ALIGN_C0 or ALIGN_C1 (package encoding); selects the input capture edge.
- SRTYPE, SR_SYNC: SR_SYNC or SR_ASYNC; sets how r_in/s_in act.

Ports:
- clk_in  in  1  single clock; the rising edge is C0, the falling edge is C1 (C1 = ~clk_in internally).
- reset_in  in  1  asynchronous, active-low reset; forces every register to INIT.
- ce_in  in  1  clock enable for data capture.
- d0_in  in  1  data for the clk-high phase.
- d1_in  in  1  data for the clk-low phase.
- r_in  in  1  reset-to-0 request, active-high.
- s_in  in  1  set-to-1 request, active-high.
- q_out  out  1  DDR output.

Behaviour:
- Registers: q0 is updated on posedge clk_in; q1 is updated on negedge clk_in.
- Output: q_out = clk_in ? q0 : q1, purely combinational.
- reset_in low forces q0, q1 and all alignment registers to INIT immediately, so q_out = INIT. This dominates r_in, s_in and ce_in. On reset release, registers update at their next own edge.
- Per-register update priority at its own edge (SR_SYNC):
  - r_in=1 → 0;
  - else s_in=1 → 1;
  - else ce_in=1 → aligned data;
  - else hold.
  - r_in beats s_in when both are high.
- SR_ASYNC: r_in and s_in act on q0 and q1 immediately without a clock, with the same priority (r over s). ce_in and data only take effect at clock edges.
- ALIGN_NONE:
  - q0 captures d0_in at posedge, so it appears on q_out in the same high phase.
  - q1 captures d1_in at negedge, appearing in the same low phase.
- ALIGN_C0:
  - d0_in and d1_in are both sampled at posedge (when ce_in=1); q0 takes d0_in.
  - The d1 sample is held in an internal stage register and loaded into q1 at the following negedge.
  - r/s still apply at q1's own edge.
- ALIGN_C1:
  - d0_in and d1_in are both sampled at negedge (when ce_in=1); q1 takes d1_in.
  - The d0 sample is staged and loaded into q0 at the next posedge.
- Stage registers follow the same ce_in gating. They are cleared to 0 by r and set to 1 by s, at their capture edge (sync) or immediately (async).
- Power-up (initial) value: all registers = INIT.
- Forwarded-clock idle case: with D0=1, D1=0 and s_in=1, q_out stays 1 through both phases.
- Forwarded-clock active case: with s_in=0, r_in=0 and ce_in=1, q_out is a copy of clk_in.
- Illegal parameter encodings are a fatal elaboration-time error.

Optional Feature:
- Macro ODDR2_CE_EN.
- Defined: ce_in gates data capture as described above.
- Undefined: ce_in is ignored and treated as 1; the port is kept for interface stability. r_in and s_in behave identically in both cases.

Decomposition:
- Package oddr2_pkg holds:
  - alignment enum constants ALIGN_NONE=0, ALIGN_C0=1, ALIGN_C1=2;
  - SR type constants SR_SYNC=0, SR_ASYNC=1;
  - a parameter-legality check function.
- One natural sub-module, ddr_edge_reg: a single-bit register with edge-select parameter, INIT, SRTYPE, ce, r, s and async active-low reset. It is instanced for q0, q1 and the alignment stage.

Test Plan:
- reset_in=0 with clk_in toggling and d0/d1=0/0 → q_out=1 (INIT) throughout. Release reset, d0=1, d1=0, ce=1, s=r=0 → q_out tracks clk_in from the next posedge.
- ALIGN_NONE, d0=1, d1=0, then s_in=1 for 4 cycles → q_out stays 1 in both phases. Drop s_in → toggling resumes at the next posedge/negedge.
- SR_SYNC, r_in=1 and s_in=1 together → q_out=0 after the next posedge (q0) and negedge (q1). r_in alone mid-high-phase → q_out is unchanged until the edge.
- SR_ASYNC, assert r_in mid-high-phase → q_out=0 immediately, with no clock edge.
- ALIGN_C0, d0=1 and d1=1 at posedge N, then d0=d1=0 → q_out is 1 for the high phase of cycle N and 1 for the following low phase, then 0.
- ODDR2_CE_EN defined, ce_in=0 with d0/d1 changing → q_out holds its last values. Undefined → q_out follows the data regardless of ce_in.
